credit_pool_arbiter: RTL and testbench
======================================

// Module: credit_pool_arbiter
// PURPOSE
//  Shares a pool of COUNT identical credits (buffer slots, tags, bus tokens) among NUM_REQ requesters.
//  Round-robin grants at most one credit per cycle; releases return credits to the pool.
//  Tracks free credits and per-requester holdings; flags illegal releases.
//  Sits between requesting agents and the resource whose occupancy the pool models.
// PARAMETERS
//  NUM_REQ  4   number of requesters, >=2
//  COUNT    16  total credits in pool, >=1
//  CW       $clog2(COUNT+1)  derived localparam: width of any credit count (holds 0..COUNT)
// PORTS
//  clk_i    in   1            clock; all logic on rising edge
//  rst_i    in   1            reset, synchronous, active-high
//  req_i    in   NUM_REQ      per-requester credit request, level; may drop at any time
//  gnt_o    out  NUM_REQ      one-hot-or-zero grant; acquire = req_i[i] & gnt_o[i] in same cycle
//  rel_i    in   NUM_REQ      per-requester release pulse; each set bit returns one credit
//  free_o   out  CW           credits currently free (registered)
//  held_o   out  NUM_REQ*CW   flattened per-requester held counts, requester i at [i*CW +: CW]
//  empty_o  out  1            free_o == 0
//  full_o   out  1            free_o == COUNT
//  err_o    out  1            registered 1-cycle pulse: illegal release seen previous cycle
// BEHAVIOUR
//  Reset (rst_i=1 at edge): free=COUNT, held[*]=0, rr pointer=0, err_o=0; gnt_o=0 while rst_i=1.
//  Reset mid-operation: all credits reclaimed, holdings discarded, no err.
//  Grant (combinational, 0 latency): if free>0, gnt_o selects first requester with req_i set,
//   searching ptr, ptr+1, ... wrapping mod NUM_REQ; else gnt_o=0. At most one grant/cycle.
//  Pointer: on acquire by i, ptr <= (i+1) mod NUM_REQ; no acquire -> ptr unchanged.
//  Release legality: rel_i[i] valid only if held[i] (pre-edge value) > 0; grant to i in the
//   same cycle does not make a release by i legal.
//  Invalid release: ignored for counts; err_o=1 next cycle (any number of bad bits -> one pulse).
//  Counts per cycle: held[i] <= held[i] + acq[i] - vrel[i];
//   free <= free - |acq + popcount(vrel). Acquire and releases in same cycle both apply.
//  Empty boundary: free=0 -> no grant even if releases arrive that cycle; freed credit grantable
//   next cycle. Full boundary: free cannot exceed COUNT by conservation (sum held + free == COUNT
//   always); overflow impossible under legal use, invalid releases never increment.
//  Invariant checked every cycle: free + sum(held) == COUNT.
//  Requester dropping req_i without gnt_o: no state change, no penalty.
// STRUCTURE
//  credit_pool_pkg: function/localparam for CW given COUNT, typedef for count type, popcount fn.
//  Sub-module rr_arbiter #(N): combinational; inputs req, ptr, en; output one-hot gnt via
//   double-width masked priority search. Top holds ptr, free, held regs, err reg, legality logic.
// TESTING
//  1 Reset: rst_i=1 two cycles -> free_o=16, full_o=1, held all 0, gnt_o=0, err_o=0.
//  2 RR fairness: req_i=4'b1111 held 8 cycles, no rel -> grants 0,1,2,3,0,1,2,3; free_o=8;
//    held each 2.
//  3 Exhaust: COUNT=16, req_i=4'b0001 for 20 cycles -> 16 grants, then gnt_o=0, empty_o=1,
//    free_o=0; rel_i[0] pulse -> free_o=1 next cycle, grant following cycle.
//  4 Simultaneous: free=3, req_i[2]=1 granted and rel_i=4'b0011 (held0=1,held1=1) same cycle
//    -> free_o=4, held0=0, held1=0, held2+1.
//  5 Illegal release: held3=0, rel_i=4'b1000 -> err_o=1 next cycle only, free_o/held unchanged.
//  6 Reset mid-op: free=5 with outstanding holdings, rst_i=1 one cycle -> free_o=16,
//    held all 0, ptr=0 (req 4'b1111 next grants requester 0).

Source files
------------

// File: rtl/credit_pool_pkg.sv
// Shared types and helpers for the credit pool arbiter.
package credit_pool_pkg;

   localparam int unsigned DEF_NUM_REQ = 4;
   localparam int unsigned DEF_COUNT   = 16;
   localparam int unsigned DEF_CW      = $clog2(DEF_COUNT + 1);
   // Widest request vector the popcount helper accepts.
   localparam int unsigned MAX_REQ     = 64;

   // Credit count for a pool of the default size.
   typedef logic [DEF_CW-1:0] count_t;

   // Width needed to hold any credit count from 0 to count inclusive.
   function automatic int unsigned cnt_width(input int unsigned count);
      return $clog2(count + 1);
   endfunction

   // Number of set bits in a (zero-extended) request-sized vector.
   function automatic int unsigned popcount(input logic [MAX_REQ-1:0] v);
      int unsigned n;
      n = 0;
      for (int unsigned i = 0; i < MAX_REQ; i++) begin
         if (v[i]) n++;
      end
      return n;
   endfunction

endpackage

// File: rtl/credit_pool_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first request at or after ptr, wrapping.
module rr_arbiter #(
   parameter  int unsigned N  = 4,
   localparam int unsigned PW = $clog2(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [PW-1:0] ptr_i,
   input  logic          en_i,
   output logic [N-1:0]  gnt_o
);

   logic [N-1:0]   mask;
   logic [2*N-1:0] dbl;
   logic           found;

   // Lower half keeps only requests at or above ptr; upper half supplies the wrap-around.
   always_comb begin
      mask = '0;
      for (int unsigned i = 0; i < N; i++) begin
         mask[i] = (PW'(i) >= ptr_i);
      end
      dbl   = {req_i, req_i & mask};
      gnt_o = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < 2 * N; i++) begin
         if (!found && dbl[i]) begin
            found        = 1'b1;
            gnt_o[i % N] = en_i;
         end
      end
   end

endmodule

// File: rtl/credit_pool_arbiter.sv
// Credit pool shared round-robin among requesters, with per-requester holdings
// and detection of releases from requesters holding nothing.
module credit_pool_arbiter
   import credit_pool_pkg::*;
#(
   parameter  int unsigned NUM_REQ = DEF_NUM_REQ,
   parameter  int unsigned COUNT   = DEF_COUNT,
   localparam int unsigned CW      = cnt_width(COUNT)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [NUM_REQ-1:0]    req_i,
   output logic [NUM_REQ-1:0]    gnt_o,
   input  logic [NUM_REQ-1:0]    rel_i,
   output logic [CW-1:0]         free_o,
   output logic [NUM_REQ*CW-1:0] held_o,
   output logic                  empty_o,
   output logic                  full_o,
   output logic                  err_o
);

   localparam int unsigned PW = $clog2(NUM_REQ);

   logic [PW-1:0]      ptr_q, ptr_d;
   logic [CW-1:0]      free_q, free_d;
   logic [CW-1:0]      held_q [NUM_REQ];
   logic [CW-1:0]      held_d [NUM_REQ];
   logic               err_q, err_d;
   logic               arb_en;
   logic [NUM_REQ-1:0] acq;
   logic [NUM_REQ-1:0] vrel;

   // Grants only when a credit is free before this edge; same-cycle releases cannot be reused.
   always_comb begin
      arb_en = !rst_i && (free_q != '0);
   end

   rr_arbiter #(
      .N(NUM_REQ)
   ) u_arb (
      .req_i (req_i),
      .ptr_i (ptr_q),
      .en_i  (arb_en),
      .gnt_o (gnt_o)
   );

   // Acquire/release qualification and next-state counts, pointer and error flag.
   always_comb begin
      acq    = req_i & gnt_o;
      vrel   = '0;
      ptr_d  = ptr_q;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         vrel[i]   = rel_i[i] && (held_q[i] != '0);
         held_d[i] = held_q[i] + CW'(acq[i]) - CW'(vrel[i]);
         if (acq[i]) begin
            ptr_d = (i == NUM_REQ - 1) ? '0 : PW'(i + 1);
         end
      end
      free_d = free_q - CW'(|acq) + CW'(popcount(MAX_REQ'(vrel)));
      err_d  = |(rel_i & ~vrel);
   end

   // State registers with synchronous reset reclaiming every credit.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         free_q <= CW'(COUNT);
         ptr_q  <= '0;
         err_q  <= 1'b0;
         for (int unsigned i = 0; i < NUM_REQ; i++) begin
            held_q[i] <= '0;
         end
      end else begin
         free_q <= free_d;
         ptr_q  <= ptr_d;
         err_q  <= err_d;
         for (int unsigned i = 0; i < NUM_REQ; i++) begin
            held_q[i] <= held_d[i];
         end
      end
   end

   // Registered status outputs and flattened holdings.
   always_comb begin
      free_o  = free_q;
      empty_o = (free_q == '0);
      full_o  = (free_q == CW'(COUNT));
      err_o   = err_q;
      held_o  = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         held_o[i*CW +: CW] = held_q[i];
      end
   end

endmodule

// File: tb/tb_credit_pool_arbiter.sv
// Self-checking bench for credit_pool_arbiter (NUM_REQ=4, COUNT=16).
module tb_credit_pool_arbiter;

   localparam int unsigned NR = 4;
   localparam int unsigned CT = 16;
   localparam int unsigned CW = 5;

   logic             clk;
   logic             rst_i;
   logic [NR-1:0]    req_i;
   logic [NR-1:0]    gnt_o;
   logic [NR-1:0]    rel_i;
   logic [CW-1:0]    free_o;
   logic [NR*CW-1:0] held_o;
   logic             empty_o;
   logic             full_o;
   logic             err_o;

   typedef logic [NR-1:0][CW-1:0] held_t;

   typedef struct {
      logic          rst;
      logic [NR-1:0] req;
      logic [NR-1:0] rel;
      logic [NR-1:0] gnt;
      int            free;
      held_t         held;
      logic          err;
   } vec_t;

   typedef struct {
      string tag;
      int    free;
      held_t held;
      logic  err;
   } exp_t;

   vec_t tbl[$];
   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   credit_pool_arbiter #(
      .NUM_REQ(NR),
      .COUNT  (CT)
   ) dut (
      .clk_i   (clk),
      .rst_i   (rst_i),
      .req_i   (req_i),
      .gnt_o   (gnt_o),
      .rel_i   (rel_i),
      .free_o  (free_o),
      .held_o  (held_o),
      .empty_o (empty_o),
      .full_o  (full_o),
      .err_o   (err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic held_t h(input int a, input int b, input int c, input int d);
      held_t r;
      r[0] = CW'(a);
      r[1] = CW'(b);
      r[2] = CW'(c);
      r[3] = CW'(d);
      return r;
   endfunction

   function automatic vec_t mk(input logic rst, input logic [NR-1:0] req, input logic [NR-1:0] rel,
                               input logic [NR-1:0] gnt, input int free, input held_t held,
                               input logic err);
      vec_t v;
      v.rst  = rst;
      v.req  = req;
      v.rel  = rel;
      v.gnt  = gnt;
      v.free = free;
      v.held = held;
      v.err  = err;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Drive one cycle: check the combinational grant mid-cycle, queue the
   // expected registered state, then compare it just after the edge.
   task automatic step(input string tag, input logic rst, input logic [NR-1:0] req,
                       input logic [NR-1:0] rel, input logic [NR-1:0] exp_gnt,
                       input int exp_free, input held_t exp_held, input logic exp_err);
      exp_t e;
      int   sum;
      rst_i = rst;
      req_i = req;
      rel_i = rel;
      @(negedge clk);
      chk({tag, ".gnt"}, 64'(gnt_o), 64'(exp_gnt));
      e.tag  = tag;
      e.free = exp_free;
      e.held = exp_held;
      e.err  = exp_err;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         chk({tag, ".sb_empty"}, 64'(1), 64'(0));
      end else begin
         e = sb.pop_front();
         chk({e.tag, ".free"},  64'(free_o),  64'(e.free));
         chk({e.tag, ".held"},  64'(held_o),  64'(e.held));
         chk({e.tag, ".err"},   64'(err_o),   64'(e.err));
         chk({e.tag, ".empty"}, 64'(empty_o), 64'(e.free == 0));
         chk({e.tag, ".full"},  64'(full_o),  64'(e.free == CT));
         sum = int'(free_o);
         for (int i = 0; i < NR; i++) sum += int'(held_o[i*CW +: CW]);
         chk({e.tag, ".conserve"}, 64'(sum), 64'(CT));
      end
   endtask

   initial begin
      rst_i = 1'b1;
      req_i = '0;
      rel_i = '0;

      // Reset, round-robin fairness, releases, illegal release.
      tbl.push_back(mk(1, 4'b0000, 4'b0000, 4'b0000, 16, h(0,0,0,0), 0));
      tbl.push_back(mk(1, 4'b0000, 4'b0000, 4'b0000, 16, h(0,0,0,0), 0));
      tbl.push_back(mk(0, 4'b1111, 4'b0000, 4'b0001, 15, h(1,0,0,0), 0));
      tbl.push_back(mk(0, 4'b1111, 4'b0000, 4'b0010, 14, h(1,1,0,0), 0));
      tbl.push_back(mk(0, 4'b1111, 4'b0000, 4'b0100, 13, h(1,1,1,0), 0));
      tbl.push_back(mk(0, 4'b1111, 4'b0000, 4'b1000, 12, h(1,1,1,1), 0));
      tbl.push_back(mk(0, 4'b1111, 4'b0000, 4'b0001, 11, h(2,1,1,1), 0));
      tbl.push_back(mk(0, 4'b1111, 4'b0000, 4'b0010, 10, h(2,2,1,1), 0));
      tbl.push_back(mk(0, 4'b1111, 4'b0000, 4'b0100,  9, h(2,2,2,1), 0));
      tbl.push_back(mk(0, 4'b1111, 4'b0000, 4'b1000,  8, h(2,2,2,2), 0));
      tbl.push_back(mk(0, 4'b0000, 4'b0001, 4'b0000,  9, h(1,2,2,2), 0));
      tbl.push_back(mk(0, 4'b0000, 4'b0010, 4'b0000, 10, h(1,1,2,2), 0));
      tbl.push_back(mk(0, 4'b0000, 4'b1100, 4'b0000, 12, h(1,1,1,1), 0));
      tbl.push_back(mk(0, 4'b0000, 4'b1000, 4'b0000, 13, h(1,1,1,0), 0));
      tbl.push_back(mk(0, 4'b0000, 4'b1000, 4'b0000, 13, h(1,1,1,0), 1));
      tbl.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 13, h(1,1,1,0), 0));
      tbl.push_back(mk(0, 4'b0011, 4'b1000, 4'b0001, 12, h(2,1,1,0), 1));
      tbl.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 12, h(2,1,1,0), 0));

      foreach (tbl[i]) begin
         step($sformatf("tbl%0d", i), tbl[i].rst, tbl[i].req, tbl[i].rel, tbl[i].gnt,
              tbl[i].free, tbl[i].held, tbl[i].err);
      end

      // Simultaneous acquire and releases with free=3.
      step("pre_rel0", 0, 4'b0000, 4'b0001, 4'b0000, 13, h(1,1,1,0), 0);
      for (int k = 0; k < 10; k++) begin
         step($sformatf("drain%0d", k), 0, 4'b0100, 4'b0000, 4'b0100, 12 - k, h(1,1,2+k,0), 0);
      end
      step("simul", 0, 4'b0100, 4'b0011, 4'b0100, 4, h(0,0,12,0), 0);

      // Reset mid-operation: holdings discarded, pointer back to 0, no error.
      step("pre_rst", 0, 4'b0000, 4'b0100, 4'b0000, 5, h(0,0,11,0), 0);
      step("midrst", 1, 4'b1111, 4'b1000, 4'b0000, 16, h(0,0,0,0), 0);
      step("post_rst", 0, 4'b1111, 4'b0000, 4'b0001, 15, h(1,0,0,0), 0);

      // Exhaust the pool from one requester, then recover one credit.
      step("rst2", 1, 4'b0001, 4'b0000, 4'b0000, 16, h(0,0,0,0), 0);
      for (int k = 0; k < 20; k++) begin
         if (k < 16)
            step($sformatf("exh%0d", k), 0, 4'b0001, 4'b0000, 4'b0001, 15 - k, h(k+1,0,0,0), 0);
         else
            step($sformatf("exh%0d", k), 0, 4'b0001, 4'b0000, 4'b0000, 0, h(16,0,0,0), 0);
      end
      step("empty_rel", 0, 4'b0001, 4'b0001, 4'b0000, 1, h(15,0,0,0), 0);
      step("regrant", 0, 4'b0001, 4'b0000, 4'b0001, 0, h(16,0,0,0), 0);
      step("idle_end", 0, 4'b0000, 4'b0000, 4'b0000, 0, h(16,0,0,0), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
